// File: rtl/flash_cmd_sequencer_if.sv
// Serial handshake and flash control bundle for flash_cmd_sequencer.
// The master modport is the sequencer; slave is the serial/flash side.
interface flash_cmd_sequencer_if;
  logic       RS_FLOW;
  logic [7:0] RS_DATAIN;
  logic [7:0] RS_DATAOUT;
  logic       RS_TRG_READ;
  logic       RS_TRG_WRITE;
  logic       RS_DONE;
  logic [7:0] FL_ADDR;
  logic       FL_TRG;
  logic       FL_STATUS;
  logic       FL_FLOW;
  logic       BUSY;

  modport master (
    output RS_FLOW, RS_DATAIN, RS_TRG_READ, RS_TRG_WRITE,
    output FL_ADDR, FL_TRG, FL_FLOW, BUSY,
    input  RS_DATAOUT, RS_DONE, FL_STATUS
  );

  modport slave (
    input  RS_FLOW, RS_DATAIN, RS_TRG_READ, RS_TRG_WRITE,
    input  FL_ADDR, FL_TRG, FL_FLOW, BUSY,
    output RS_DATAOUT, RS_DONE, FL_STATUS
  );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// Serial command front-end for a byte-wide flash: 'W' addr data / 'R' addr, one reply byte.
// Define FL_TIMEOUT_EN to abort a stuck flash operation after TIMEOUT_CYCLES with reply 'T'.
module flash_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                  CLK_50MHZ,
  input  logic                  RST,
  flash_cmd_sequencer_if.master bus,
  inout  wire  [7:0]            FL_DATA
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_ADDR, GET_DATA, FL_START, FL_WAIT, SEND, SEND_WAIT
  } state_t;

  localparam logic [7:0] CMD_WRITE    = 8'h57;
  localparam logic [7:0] CMD_READ     = 8'h52;
  localparam logic [7:0] RESP_BAD     = 8'h3F;
  localparam logic [7:0] RESP_OK      = 8'h4B;
  localparam logic [7:0] RESP_TIMEOUT = 8'h54;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t        state;
  logic          is_write;
  logic          rs_flow;
  logic          rs_trg_read;
  logic          rs_trg_write;
  logic          fl_trg;
  logic          fl_flow;
  logic [7:0]    rs_datain;
  logic [7:0]    fl_addr;
  logic [7:0]    wr_data;
  logic [SW-1:0] settle_cnt;
  logic          settled;
  logic          rx_done;

`ifdef FL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_cnt;
  logic          timed_out;
  assign timed_out = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  assign settled = (settle_cnt == SW'(SETTLE_CYCLES));
  // A byte cannot complete in the cycle it was armed, so keep read pulses apart
  assign rx_done = bus.RS_DONE && !rs_trg_read;

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      rs_flow      <= 1'b0;
      rs_trg_read  <= 1'b0;
      rs_trg_write <= 1'b0;
      fl_trg       <= 1'b0;
      fl_flow      <= 1'b0;
      rs_datain    <= 8'h00;
      fl_addr      <= 8'h00;
      wr_data      <= 8'h00;
      settle_cnt   <= '0;
`ifdef FL_TIMEOUT_EN
      timeout_cnt  <= '0;
`endif
    end else begin
      rs_trg_read  <= 1'b0;
      rs_trg_write <= 1'b0;
      fl_trg       <= 1'b0;
      case (state)
        IDLE: begin
          rs_flow     <= 1'b0;
          rs_trg_read <= 1'b1;
          state       <= GET_CMD;
        end
        GET_CMD: if (rx_done) begin
          if (bus.RS_DATAOUT == CMD_WRITE || bus.RS_DATAOUT == CMD_READ) begin
            is_write    <= (bus.RS_DATAOUT == CMD_WRITE);
            rs_trg_read <= 1'b1;
            state       <= GET_ADDR;
          end else begin
            rs_datain    <= RESP_BAD;
            rs_flow      <= 1'b1;
            rs_trg_write <= 1'b1;
            state        <= SEND;
          end
        end
        GET_ADDR: if (rx_done) begin
          fl_addr <= bus.RS_DATAOUT;
          if (is_write) begin
            rs_trg_read <= 1'b1;
            state       <= GET_DATA;
          end else begin
            fl_flow <= 1'b0;
            fl_trg  <= 1'b1;
            state   <= FL_START;
          end
        end
        GET_DATA: if (rx_done) begin
          wr_data <= bus.RS_DATAOUT;
          fl_flow <= 1'b1;
          fl_trg  <= 1'b1;
          state   <= FL_START;
        end
        FL_START: begin
          settle_cnt  <= '0;
`ifdef FL_TIMEOUT_EN
          timeout_cnt <= '0;
`endif
          state       <= FL_WAIT;
        end
        // Reply outputs are set on the exit edge so RS_TRG_WRITE follows FL_STATUS=0 by one cycle
        FL_WAIT: begin
          if (!settled) settle_cnt <= settle_cnt + SW'(1);
`ifdef FL_TIMEOUT_EN
          timeout_cnt <= timeout_cnt + TW'(1);
`endif
          if (settled && !bus.FL_STATUS) begin
            rs_datain    <= is_write ? RESP_OK : FL_DATA;
            fl_flow      <= 1'b0;
            rs_flow      <= 1'b1;
            rs_trg_write <= 1'b1;
            state        <= SEND;
          end
`ifdef FL_TIMEOUT_EN
          else if (timed_out) begin
            rs_datain    <= RESP_TIMEOUT;
            fl_flow      <= 1'b0;
            rs_flow      <= 1'b1;
            rs_trg_write <= 1'b1;
            state        <= SEND;
          end
`endif
        end
        SEND: state <= SEND_WAIT;
        SEND_WAIT: if (bus.RS_DONE) begin
          rs_flow <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign FL_DATA          = fl_flow ? wr_data : 8'hzz;
  assign bus.RS_FLOW      = rs_flow;
  assign bus.RS_DATAIN    = rs_datain;
  assign bus.RS_TRG_READ  = rs_trg_read;
  assign bus.RS_TRG_WRITE = rs_trg_write;
  assign bus.FL_ADDR      = fl_addr;
  assign bus.FL_TRG       = fl_trg;
  assign bus.FL_FLOW      = fl_flow;
  assign bus.BUSY         = (state != IDLE);

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer: write, read, bad command, mid-op reset,
// spurious RS_DONE and FL_WAIT timeout (behaviour depends on FL_TIMEOUT_EN).
module tb_flash_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flash_drive_en = 1'b0;
  logic [7:0] flash_drive_val = 8'h00;
  wire  [7:0] fl_data;

  int total = 0;
  int bad   = 0;
  int fl_trg_count = 0;
  int rd_count = 0;
  int consec_bad = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_fl = 1'b0;

  flash_cmd_sequencer_if bus();

  assign fl_data = flash_drive_en ? flash_drive_val : 8'hzz;

  flash_cmd_sequencer #(.TIMEOUT_CYCLES(8), .SETTLE_CYCLES(2)) dut (
    .CLK_50MHZ(clk),
    .RST      (rst),
    .bus      (bus),
    .FL_DATA  (fl_data)
  );

  always #10 clk = ~clk;

  // Pulse counters and back-to-back strobe detection, sampled on each edge
  always @(posedge clk) begin
    if (bus.FL_TRG) fl_trg_count++;
    if (bus.RS_TRG_READ) rd_count++;
    if ((bus.RS_TRG_READ && prev_rd) || (bus.RS_TRG_WRITE && prev_wr) || (bus.FL_TRG && prev_fl))
      consec_bad++;
    prev_rd = bus.RS_TRG_READ;
    prev_wr = bus.RS_TRG_WRITE;
    prev_fl = bus.FL_TRG;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial receiver model: waits for the arming pulse, then delivers one byte
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.RS_TRG_READ) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      tick();
      bus.RS_DATAOUT = b;
      bus.RS_DONE = 1'b1;
      tick();
      bus.RS_DONE = 1'b0;
    end
  endtask

  // From the SEND cycle: let the transmitter finish and return to IDLE
  task automatic finish_reply();
    tick();
    bus.RS_DONE = 1'b1;
    tick();
    bus.RS_DONE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (bus.RS_FLOW !== 1'b0) begin bad++; $display("[TB] FAIL rst_rs_flow got=%b exp=0", bus.RS_FLOW); end
    total++; if (bus.RS_DATAIN !== 8'h00) begin bad++; $display("[TB] FAIL rst_rs_datain got=%h exp=00", bus.RS_DATAIN); end
    total++; if (bus.RS_TRG_READ !== 1'b0 || bus.RS_TRG_WRITE !== 1'b0) begin bad++; $display("[TB] FAIL rst_rs_trg got=%b%b exp=00", bus.RS_TRG_READ, bus.RS_TRG_WRITE); end
    total++; if (bus.FL_ADDR !== 8'h00) begin bad++; $display("[TB] FAIL rst_fl_addr got=%h exp=00", bus.FL_ADDR); end
    total++; if (bus.FL_TRG !== 1'b0 || bus.FL_FLOW !== 1'b0) begin bad++; $display("[TB] FAIL rst_fl_ctrl got=%b%b exp=00", bus.FL_TRG, bus.FL_FLOW); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", bus.BUSY); end
    rst = 1'b1;
    tick();
    total++; if (bus.RS_TRG_READ !== 1'b1 || bus.RS_FLOW !== 1'b0) begin bad++; $display("[TB] FAIL rst_first_read got=%b flow=%b exp=1 flow=0", bus.RS_TRG_READ, bus.RS_FLOW); end
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy_after got=%b exp=1", bus.BUSY); end
  endtask

  task automatic test_write();
    bit ok, hs, stable;
    int c0 = fl_trg_count;
    hs = 1'b1;
    send_byte(8'h57, ok); hs &= ok;
    send_byte(8'h10, ok); hs &= ok;
    send_byte(8'hA5, ok); hs &= ok;
    total++; if (hs !== 1'b1) begin bad++; $display("[TB] FAIL wr_handshake got=%b exp=1", hs); end
    total++; if (bus.FL_TRG !== 1'b1 || bus.FL_FLOW !== 1'b1) begin bad++; $display("[TB] FAIL wr_start got trg=%b flow=%b exp 1 1", bus.FL_TRG, bus.FL_FLOW); end
    total++; if (bus.FL_ADDR !== 8'h10) begin bad++; $display("[TB] FAIL wr_addr got=%h exp=10", bus.FL_ADDR); end
    total++; if (fl_data !== 8'hA5) begin bad++; $display("[TB] FAIL wr_fl_data got=%h exp=a5", fl_data); end
    bus.FL_STATUS = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.FL_FLOW !== 1'b1 || bus.FL_ADDR !== 8'h10 || bus.FL_TRG !== 1'b0 || bus.RS_TRG_WRITE !== 1'b0)
        stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("[TB] FAIL wr_wait_stable got=%b exp=1", stable); end
    bus.FL_STATUS = 1'b0;
    tick();
    total++; if (bus.RS_TRG_WRITE !== 1'b1 || bus.RS_FLOW !== 1'b1) begin bad++; $display("[TB] FAIL wr_reply_strobe got trg=%b flow=%b exp 1 1", bus.RS_TRG_WRITE, bus.RS_FLOW); end
    total++; if (bus.RS_DATAIN !== 8'h4B) begin bad++; $display("[TB] FAIL wr_reply_byte got=%h exp=4b", bus.RS_DATAIN); end
    total++; if (bus.FL_FLOW !== 1'b0) begin bad++; $display("[TB] FAIL wr_flow_release got=%b exp=0", bus.FL_FLOW); end
    tick();
    total++; if (bus.RS_TRG_WRITE !== 1'b0 || bus.RS_DATAIN !== 8'h4B || bus.RS_FLOW !== 1'b1) begin bad++; $display("[TB] FAIL wr_send_wait_hold got trg=%b data=%h flow=%b exp 0 4b 1", bus.RS_TRG_WRITE, bus.RS_DATAIN, bus.RS_FLOW); end
    bus.RS_DONE = 1'b1;
    tick();
    bus.RS_DONE = 1'b0;
    total++; if (bus.RS_FLOW !== 1'b0 || bus.BUSY !== 1'b0) begin bad++; $display("[TB] FAIL wr_back_idle got flow=%b busy=%b exp 0 0", bus.RS_FLOW, bus.BUSY); end
    total++; if (fl_trg_count - c0 !== 1) begin bad++; $display("[TB] FAIL wr_fl_trg_count got=%0d exp=1", fl_trg_count - c0); end
  endtask

  task automatic test_read();
    bit ok, hs;
    int c0 = fl_trg_count;
    hs = 1'b1;
    send_byte(8'h52, ok); hs &= ok;
    send_byte(8'h22, ok); hs &= ok;
    total++; if (hs !== 1'b1) begin bad++; $display("[TB] FAIL rd_handshake got=%b exp=1", hs); end
    total++; if (bus.FL_TRG !== 1'b1 || bus.FL_FLOW !== 1'b0 || bus.FL_ADDR !== 8'h22) begin bad++; $display("[TB] FAIL rd_start got trg=%b flow=%b addr=%h exp 1 0 22", bus.FL_TRG, bus.FL_FLOW, bus.FL_ADDR); end
    bus.FL_STATUS = 1'b1;
    repeat (4) tick();
    bus.FL_STATUS = 1'b0;
    flash_drive_val = 8'h3C;
    flash_drive_en = 1'b1;
    tick();
    flash_drive_en = 1'b0;
    total++; if (bus.RS_TRG_WRITE !== 1'b1) begin bad++; $display("[TB] FAIL rd_latency got=%b exp=1", bus.RS_TRG_WRITE); end
    total++; if (bus.RS_DATAIN !== 8'h3C) begin bad++; $display("[TB] FAIL rd_reply_byte got=%h exp=3c", bus.RS_DATAIN); end
    total++; if (bus.FL_FLOW !== 1'b0) begin bad++; $display("[TB] FAIL rd_flow got=%b exp=0", bus.FL_FLOW); end
    finish_reply();
    total++; if (fl_trg_count - c0 !== 1) begin bad++; $display("[TB] FAIL rd_fl_trg_count got=%0d exp=1", fl_trg_count - c0); end
  endtask

  task automatic test_bad_cmd();
    bit ok;
    int c0 = fl_trg_count;
    send_byte(8'h00, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL bad_handshake got=%b exp=1", ok); end
    total++; if (bus.RS_TRG_WRITE !== 1'b1 || bus.RS_DATAIN !== 8'h3F) begin bad++; $display("[TB] FAIL bad_reply got trg=%b data=%h exp 1 3f", bus.RS_TRG_WRITE, bus.RS_DATAIN); end
    finish_reply();
    total++; if (fl_trg_count - c0 !== 0) begin bad++; $display("[TB] FAIL bad_no_fl_trg got=%0d exp=0", fl_trg_count - c0); end
  endtask

  task automatic test_reset_mid();
    bit ok, hs;
    hs = 1'b1;
    send_byte(8'h52, ok); hs &= ok;
    send_byte(8'h33, ok); hs &= ok;
    bus.FL_STATUS = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    total++; if (bus.BUSY !== 1'b0 || bus.FL_ADDR !== 8'h00 || bus.FL_FLOW !== 1'b0 || bus.FL_TRG !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_fl got busy=%b addr=%h flow=%b trg=%b exp 0 00 0 0", bus.BUSY, bus.FL_ADDR, bus.FL_FLOW, bus.FL_TRG); end
    total++; if (bus.RS_FLOW !== 1'b0 || bus.RS_DATAIN !== 8'h00 || bus.RS_TRG_READ !== 1'b0 || bus.RS_TRG_WRITE !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_rs got flow=%b data=%h rd=%b wr=%b exp 0 00 0 0", bus.RS_FLOW, bus.RS_DATAIN, bus.RS_TRG_READ, bus.RS_TRG_WRITE); end
    rst = 1'b1;
    tick();
    total++; if (bus.RS_TRG_READ !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_restart got=%b exp=1", bus.RS_TRG_READ); end
    send_byte(8'h52, ok); hs &= ok;
    send_byte(8'h44, ok); hs &= ok;
    total++; if (hs !== 1'b1 || bus.FL_ADDR !== 8'h44) begin bad++; $display("[TB] FAIL mid_rst_new_addr got hs=%b addr=%h exp 1 44", hs, bus.FL_ADDR); end
    repeat (3) tick();
    bus.FL_STATUS = 1'b0;
    flash_drive_val = 8'h5A;
    flash_drive_en = 1'b1;
    tick();
    flash_drive_en = 1'b0;
    total++; if (bus.RS_TRG_WRITE !== 1'b1 || bus.RS_DATAIN !== 8'h5A) begin bad++; $display("[TB] FAIL mid_rst_reply got trg=%b data=%h exp 1 5a", bus.RS_TRG_WRITE, bus.RS_DATAIN); end
    finish_reply();
  endtask

  task automatic test_spurious();
    bit ok, hs, quiet;
    int r0;
    hs = 1'b1;
    send_byte(8'h52, ok); hs &= ok;
    send_byte(8'h66, ok); hs &= ok;
    total++; if (hs !== 1'b1) begin bad++; $display("[TB] FAIL sp_handshake got=%b exp=1", hs); end
    r0 = rd_count;
    bus.FL_STATUS = 1'b1;
    bus.RS_DATAOUT = 8'h57;
    bus.RS_DONE = 1'b1;
    tick();
    bus.RS_DONE = 1'b0;
    tick();
    bus.RS_DONE = 1'b1;
    tick();
    bus.RS_DONE = 1'b0;
    quiet = (bus.BUSY === 1'b1) && (bus.FL_FLOW === 1'b0) && (bus.RS_TRG_WRITE === 1'b0);
    tick();
    bus.FL_STATUS = 1'b0;
    flash_drive_val = 8'hC3;
    flash_drive_en = 1'b1;
    tick();
    flash_drive_en = 1'b0;
    total++; if (quiet !== 1'b1 || rd_count - r0 !== 0) begin bad++; $display("[TB] FAIL sp_no_state_change got quiet=%b reads=%0d exp 1 0", quiet, rd_count - r0); end
    total++; if (bus.RS_TRG_WRITE !== 1'b1 || bus.RS_DATAIN !== 8'hC3) begin bad++; $display("[TB] FAIL sp_reply got trg=%b data=%h exp 1 c3", bus.RS_TRG_WRITE, bus.RS_DATAIN); end
    bus.RS_DONE = 1'b1;
    tick();
    bus.RS_DONE = 1'b0;
    total++; if (bus.RS_FLOW !== 1'b1 || bus.BUSY !== 1'b1) begin bad++; $display("[TB] FAIL sp_send_ignores_done got flow=%b busy=%b exp 1 1", bus.RS_FLOW, bus.BUSY); end
    bus.RS_DONE = 1'b1;
    tick();
    bus.RS_DONE = 1'b0;
    total++; if (bus.RS_FLOW !== 1'b0 || bus.BUSY !== 1'b0) begin bad++; $display("[TB] FAIL sp_done got flow=%b busy=%b exp 0 0", bus.RS_FLOW, bus.BUSY); end
  endtask

  task automatic test_timeout();
    bit ok, hs, seen;
    int n;
    hs = 1'b1;
    send_byte(8'h52, ok); hs &= ok;
    send_byte(8'h55, ok); hs &= ok;
    total++; if (hs !== 1'b1) begin bad++; $display("[TB] FAIL to_handshake got=%b exp=1", hs); end
    bus.FL_STATUS = 1'b1;
    flash_drive_val = 8'hEE;
    flash_drive_en = 1'b1;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.RS_TRG_WRITE === 1'b1) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    flash_drive_en = 1'b0;
`ifdef FL_TIMEOUT_EN
    total++; if (seen !== 1'b1 || n !== 9) begin bad++; $display("[TB] FAIL to_reply_time got seen=%b cycles=%0d exp 1 9", seen, n); end
    total++; if (bus.RS_DATAIN !== 8'h54) begin bad++; $display("[TB] FAIL to_reply_byte got=%h exp=54", bus.RS_DATAIN); end
    bus.FL_STATUS = 1'b0;
    finish_reply();
`else
    total++; if (seen !== 1'b0 || bus.BUSY !== 1'b1) begin bad++; $display("[TB] FAIL to_waits got seen=%b busy=%b exp 0 1", seen, bus.BUSY); end
    bus.FL_STATUS = 1'b0;
    flash_drive_val = 8'h77;
    flash_drive_en = 1'b1;
    tick();
    flash_drive_en = 1'b0;
    total++; if (bus.RS_TRG_WRITE !== 1'b1 || bus.RS_DATAIN !== 8'h77) begin bad++; $display("[TB] FAIL to_late_reply got trg=%b data=%h exp 1 77", bus.RS_TRG_WRITE, bus.RS_DATAIN); end
    finish_reply();
`endif
  endtask

  task automatic test_pulse_rules();
    total++; if (consec_bad !== 0) begin bad++; $display("[TB] FAIL strobe_back_to_back got=%0d exp=0", consec_bad); end
  endtask

  initial begin
    bus.RS_DATAOUT = 8'h00;
    bus.RS_DONE = 1'b0;
    bus.FL_STATUS = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_reset_mid();
    test_spurious();
    test_timeout();
    test_pulse_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
